// File: rtl/ks_adder_arbiter.sv
// ks_adder_arbiter
// ----------------
// Shares one 32-bit Kogge-Stone adder among NUM_REQ requesters. A round-robin
// arbiter picks one request per cycle. The request goes through two stages:
// an operand register (stage 1), then the combinational adder, then a result
// register (stage 2). Each result carries the index of the requester that owns it.
//
// Optional feature: define KS_ARB_SUB_EN to add the req_sub port.
// A request with sub=1 returns A - B. Bit 32 of that result is the no-borrow flag.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   req_valid  per-requester request valid
//   req_ready  per-requester accept; one-hot or zero
//   req_in1    operand A; requester i at [32*i+31:32*i]
//   req_in2    operand B, same packing
//   req_c0     per-requester carry-in
//   req_sub    per-requester subtract select (KS_ARB_SUB_EN only)
//   rsp_valid  result valid
//   rsp_ready  consumer accept
//   rsp_out    {carry, sum[31:0]}
//   rsp_id     index of the requester that owns rsp_out
module ks_adder_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [32*NUM_REQ-1:0] req_in1,
    input  logic [32*NUM_REQ-1:0] req_in2,
    input  logic [NUM_REQ-1:0]    req_c0,
`ifdef KS_ARB_SUB_EN
    input  logic [NUM_REQ-1:0]    req_sub,
`endif
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [32:0]           rsp_out,
    output logic [ID_W-1:0]       rsp_id
);

    logic [31:0]     in1_arr [NUM_REQ];
    logic [31:0]     in2_arr [NUM_REQ];

    logic [ID_W-1:0] rr_ptr_reg, rr_ptr_next;
    logic            s1_valid_reg;
    logic [31:0]     s1_in1_reg, s1_in2_reg;
    logic            s1_c0_reg;
    logic            s1_sub_reg;
    logic [ID_W-1:0] s1_id_reg;
    logic            rsp_valid_reg;
    logic [32:0]     rsp_out_reg;
    logic [ID_W-1:0] rsp_id_reg;

    logic            adv1, adv2;
    logic            grant_any;
    logic [ID_W-1:0] grant_idx;
    logic            sel_sub;
    logic [32:0]     ks_out;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign in1_arr[gi] = req_in1[32*gi +: 32];
            assign in2_arr[gi] = req_in2[32*gi +: 32];
        end
    endgenerate

`ifdef KS_ARB_SUB_EN
    assign sel_sub = |(req_sub & (NUM_REQ'(1) << grant_idx));
`else
    assign sel_sub = 1'b0;
`endif

    // Stage 2 frees up when it is empty or being drained.
    // Stage 1 frees up when it is empty or can move into stage 2.
    assign adv2 = ~rsp_valid_reg | rsp_ready;
    assign adv1 = ~s1_valid_reg | adv2;

    // Round-robin search: the first valid request at or after rr_ptr, wrapping to 0.
    always_comb begin
        int j;
        grant_any = 1'b0;
        grant_idx = '0;
        j         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(rr_ptr_reg) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!grant_any && |(req_valid & (NUM_REQ'(1) << j))) begin
                grant_any = 1'b1;
                grant_idx = ID_W'(j);
            end
        end
    end

    // Keep req_ready low during reset so that nothing is accepted and then lost.
    assign req_ready = (adv1 && grant_any && !rst) ? (NUM_REQ'(1) << grant_idx) : '0;

    assign rr_ptr_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

    // Kogge-Stone prefix adder. The adder reads its operands only from stage 1.
    // The carry-in is merged into the bit-0 generate term, so the prefix output at
    // bit i is the carry out of bit i. Each level combines every bit with the bit
    // 2^lvl positions below it. That is done with whole-vector shifts; the low bits
    // pass through unchanged.
    always_comb begin
        logic [31:0] b_eff, g, p, gg, pp, gn, pn, carries;
        logic        cin;
        b_eff = s1_sub_reg ? ~s1_in2_reg : s1_in2_reg;
        cin   = s1_sub_reg ? 1'b1 : s1_c0_reg;
        g     = s1_in1_reg & b_eff;
        p     = s1_in1_reg ^ b_eff;
        gg    = g;
        gg[0] = g[0] | (p[0] & cin);
        pp    = p;
        for (int lvl = 0; lvl < 5; lvl++) begin
            gn = gg | (pp & (gg << (1 << lvl)));
            pn = pp & ((pp << (1 << lvl)) | ((32'd1 << (1 << lvl)) - 32'd1));
            gg = gn;
            pp = pn;
        end
        carries = {gg[30:0], cin};
        ks_out  = {gg[31], p ^ carries};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg    <= '0;
            s1_valid_reg  <= 1'b0;
            s1_in1_reg    <= '0;
            s1_in2_reg    <= '0;
            s1_c0_reg     <= 1'b0;
            s1_sub_reg    <= 1'b0;
            s1_id_reg     <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_out_reg   <= '0;
            rsp_id_reg    <= '0;
        end else begin
            if (adv1) begin
                s1_valid_reg <= grant_any;
                if (grant_any) begin
                    s1_in1_reg <= in1_arr[grant_idx];
                    s1_in2_reg <= in2_arr[grant_idx];
                    s1_c0_reg  <= |(req_c0 & (NUM_REQ'(1) << grant_idx));
                    s1_sub_reg <= sel_sub;
                    s1_id_reg  <= grant_idx;
                    rr_ptr_reg <= rr_ptr_next;
                end
            end
            if (adv2) begin
                rsp_valid_reg <= s1_valid_reg;
                rsp_out_reg   <= ks_out;
                rsp_id_reg    <= s1_id_reg;
            end
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_out   = rsp_out_reg;
    assign rsp_id    = rsp_id_reg;

endmodule

// File: tb/tb_ks_adder_arbiter.sv
// Testbench for ks_adder_arbiter.
// The directed tasks check specific cycles and values. A monitor process keeps a
// reference model of the block: an in-flight queue with per-entry age, and a
// round-robin pointer. The monitor checks grants, rsp_valid and the response data
// on every cycle.
module tb_ks_adder_arbiter;
    localparam int N = 4;
    localparam int W = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [32*N-1:0] req_in1;
    logic [32*N-1:0] req_in2;
    logic [N-1:0]   req_c0;
`ifdef KS_ARB_SUB_EN
    logic [N-1:0]   req_sub;
`endif
    logic           rsp_valid;
    logic           rsp_ready;
    logic [32:0]    rsp_out;
    logic [W-1:0]   rsp_id;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [32:0] val;
        int          id;
        int          age;
    } exp_t;

    exp_t q[$];
    int   m_ptr = 0;

    ks_adder_arbiter #(.NUM_REQ(N), .ID_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_in1   (req_in1),
        .req_in2   (req_in2),
        .req_c0    (req_c0),
`ifdef KS_ARB_SUB_EN
        .req_sub   (req_sub),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_out   (rsp_out),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    // Reference arithmetic. Subtraction is A - B plus 2^32, which puts the
    // no-borrow flag in bit 32.
    function automatic logic [32:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                               input logic c, input logic s);
        if (s) return 33'(a) + 33'h1_0000_0000 - 33'(b);
        return 33'(a) + 33'(b) + 33'(c);
    endfunction

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b, input logic c);
        req_in1[32*i +: 32] = a;
        req_in2[32*i +: 32] = b;
        req_c0[i]           = c;
    endtask

    // Monitor. It samples just before each rising edge and updates the model on the edge.
    // The block can hold at most two items in flight. With two in flight it can
    // accept a new request only if the consumer takes a result in the same cycle.
    always begin : mon
        int          g;
        logic [N-1:0] exp_ready;
        logic        exp_v, take, pop, s;
        logic [32:0] val;
        @(negedge clk);
        #4;
        if (rst !== 1'b0) begin
            @(posedge clk);
            q.delete();
            m_ptr = 0;
        end else begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (g < 0 && req_valid[W'(j)] === 1'b1) g = j;
            end
            exp_ready = (g >= 0 && (q.size() < 2 || rsp_ready === 1'b1)) ? (N'(1) << g) : '0;
            total++;
            if (req_ready !== exp_ready) begin
                bad++;
                $display("FAIL grant @%0t: req_ready=%b expected %b", $time, req_ready, exp_ready);
            end
            exp_v = (q.size() > 0) && (q[0].age >= 2);
            total++;
            if (rsp_valid !== exp_v) begin
                bad++;
                $display("FAIL rsp_valid @%0t: got %b expected %b", $time, rsp_valid, exp_v);
            end
            if (exp_v) begin
                total++;
                if (rsp_out !== q[0].val || rsp_id !== W'(q[0].id)) begin
                    bad++;
                    $display("FAIL rsp_data @%0t: got out=%h id=%0d expected out=%h id=%0d",
                             $time, rsp_out, rsp_id, q[0].val, q[0].id);
                end
            end
            take = (exp_ready != '0);
            pop  = exp_v && (rsp_ready === 1'b1);
            val  = '0;
            if (take) begin
                s = 1'b0;
`ifdef KS_ARB_SUB_EN
                s = req_sub[W'(g)];
`endif
                val = ref_result(req_in1[32*g +: 32], req_in2[32*g +: 32], req_c0[W'(g)], s);
            end
            @(posedge clk);
            if (rst === 1'b1) begin
                q.delete();
                m_ptr = 0;
            end else begin
                if (pop) void'(q.pop_front());
                foreach (q[i]) q[i].age++;
                if (take) begin
                    q.push_back('{val, g, 1});
                    m_ptr = (g + 1) % N;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        req_valid = '1;
        #1;
        total++;
        if (req_ready !== '0) begin
            bad++; $display("FAIL reset_ready: got %b expected 0000", req_ready);
        end
        @(negedge clk);
        rst       = 1'b0;
        req_valid = '0;
        #1;
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid);
        end
        total++;
        if (rsp_out !== 33'h0) begin
            bad++; $display("FAIL reset_rsp_out: got %h expected 0", rsp_out);
        end
        total++;
        if (rsp_id !== 2'd0) begin
            bad++; $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id);
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        set_ops(0, 32'hFFFF_FFFF, 32'h1, 1'b0);
        req_valid = 4'b0001;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++; $display("FAIL single_grant: got %b expected 0001", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++; $display("FAIL single_early: rsp_valid=%b expected 0", rsp_valid);
        end
        @(negedge clk);
        #1;
        total++;
        if (rsp_valid !== 1'b1 || rsp_out !== 33'h1_0000_0000 || rsp_id !== 2'd0) begin
            bad++;
            $display("FAIL single_result: got v=%b out=%h id=%0d expected v=1 out=100000000 id=0",
                     rsp_valid, rsp_out, rsp_id);
        end
        @(negedge clk);
        #1;
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++; $display("FAIL single_drain: rsp_valid=%b expected 0", rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < N; i++) set_ops(i, $urandom(), $urandom(), 1'($urandom_range(1)));
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k < 8) begin
                req_valid = '1;
                if (k > 0) set_ops((k - 1) % N, $urandom(), $urandom(), 1'($urandom_range(1)));
            end else begin
                req_valid = '0;
            end
            #1;
            if (k < 8) begin
                total++;
                if (req_ready !== (N'(1) << (k % N))) begin
                    bad++;
                    $display("FAIL rr_grant k=%0d: got %b expected %b", k, req_ready, N'(1) << (k % N));
                end
            end
            if (k >= 2) begin
                total++;
                if (rsp_valid !== 1'b1 || rsp_id !== W'((k - 2) % N)) begin
                    bad++;
                    $display("FAIL rr_id k=%0d: got v=%b id=%0d expected v=1 id=%0d",
                             k, rsp_valid, rsp_id, (k - 2) % N);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int          acc;
        logic [32:0] held_out;
        logic [W-1:0] held_id;
        logic        have;
        acc  = 0;
        have = 1'b0;
        held_out = '0;
        held_id  = '0;
        set_ops(1, $urandom(), $urandom(), 1'b1);
        set_ops(2, $urandom(), $urandom(), 1'b0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            rsp_ready = 1'b0;
            req_valid = 4'b0110;
            #1;
            if (acc >= 2) begin
                total++;
                if (req_ready !== '0) begin
                    bad++; $display("FAIL bp_ready c=%0d: got %b expected 0000", c, req_ready);
                end
            end
            acc += $countones(req_ready & req_valid);
            if (rsp_valid === 1'b1) begin
                if (!have) begin
                    held_out = rsp_out;
                    held_id  = rsp_id;
                    have     = 1'b1;
                end else begin
                    total++;
                    if (rsp_out !== held_out || rsp_id !== held_id) begin
                        bad++;
                        $display("FAIL bp_stable c=%0d: got out=%h id=%0d expected out=%h id=%0d",
                                 c, rsp_out, rsp_id, held_out, held_id);
                    end
                end
            end
        end
        total++;
        if (acc != 2) begin
            bad++; $display("FAIL bp_accepted: got %0d expected 2", acc);
        end
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            rsp_ready = 1'b1;
            req_valid = '0;
            #1;
            total++;
            if (r < 2 && (rsp_valid !== 1'b1 || rsp_id !== W'(r + 1))) begin
                bad++;
                $display("FAIL bp_order r=%0d: got v=%b id=%0d expected v=1 id=%0d", r, rsp_valid, rsp_id, r + 1);
            end else if (r == 2 && rsp_valid !== 1'b0) begin
                bad++; $display("FAIL bp_empty: rsp_valid=%b expected 0", rsp_valid);
            end
        end
    endtask

    task automatic test_wrap_skip();
        logic [N-1:0] pat [4];
        logic [N-1:0] exp [4];
        pat = '{4'b0100, 4'b0010, 4'b1000, 4'b0011};
        exp = '{4'b0100, 4'b0010, 4'b1000, 4'b0001};
        do_reset();
        for (int i = 0; i < N; i++) set_ops(i, $urandom(), $urandom(), 1'($urandom_range(1)));
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            req_valid = pat[s];
            #1;
            total++;
            if (req_ready !== exp[s]) begin
                bad++; $display("FAIL wrap_skip s=%0d: got %b expected %b", s, req_ready, exp[s]);
            end
        end
        @(negedge clk);
        req_valid = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_midflight();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            rsp_ready = 1'b0;
            req_valid = '1;
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (req_ready !== '0) begin
            bad++; $display("FAIL mid_rst_ready: got %b expected 0000", req_ready);
        end
        @(negedge clk);
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        #1;
        total++;
        if (rsp_valid !== 1'b0 || rsp_out !== 33'h0 || rsp_id !== 2'd0) begin
            bad++;
            $display("FAIL mid_rst_state: got v=%b out=%h id=%0d expected v=0 out=0 id=0", rsp_valid, rsp_out, rsp_id);
        end
        @(negedge clk);
        #1;
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++; $display("FAIL mid_rst_stale: rsp_valid=%b expected 0", rsp_valid);
        end
        @(negedge clk);
        req_valid = '1;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++; $display("FAIL mid_rst_ptr: got %b expected 0001", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        logic [N-1:0] granted;
        logic [31:0]  a, b;
        granted = '0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && !granted[i]) begin
                    if ($urandom_range(7) == 0) req_valid[i] = 1'b0;
                end else begin
                    req_valid[i] = 1'($urandom_range(1));
                    a = ($urandom_range(7) == 0) ? 32'hFFFF_FFFF : $urandom();
                    b = ($urandom_range(7) == 0) ? 32'hFFFF_FFFF : $urandom();
                    set_ops(i, a, b, 1'($urandom_range(1)));
`ifdef KS_ARB_SUB_EN
                    req_sub[i] = 1'($urandom_range(1));
`endif
                end
            end
            rsp_ready = ($urandom_range(3) != 0);
            #1;
            granted = req_valid & req_ready;
            total++;
            if ((req_ready & ~req_valid) != '0 || $countones(req_ready) > 1) begin
                bad++; $display("FAIL rand_onehot c=%0d: req_ready=%b req_valid=%b", c, req_ready, req_valid);
            end
        end
        @(negedge clk);
        req_valid = '0;
    endtask

`ifdef KS_ARB_SUB_EN
    task automatic test_sub();
        @(negedge clk);
        rsp_ready  = 1'b1;
        req_valid  = 4'b0001;
        set_ops(0, 32'd5, 32'd7, 1'b1);
        req_sub[0] = 1'b1;
        @(negedge clk);
        set_ops(0, 32'd7, 32'd5, 1'b0);
        @(negedge clk);
        req_valid  = '0;
        #1;
        total++;
        if (rsp_out !== 33'h0_FFFF_FFFE) begin
            bad++; $display("FAIL sub_5_7: got %h expected 0fffffffe", rsp_out);
        end
        @(negedge clk);
        #1;
        total++;
        if (rsp_out !== 33'h1_0000_0002) begin
            bad++; $display("FAIL sub_7_5: got %h expected 100000002", rsp_out);
        end
        req_sub = '0;
    endtask
`endif

    task automatic test_drain();
        int cyc;
        cyc = 0;
        rsp_ready = 1'b1;
        req_valid = '0;
        while (q.size() != 0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        repeat (2) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++; $display("FAIL drain: %0d results still outstanding", q.size());
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_in1   = '0;
        req_in2   = '0;
        req_c0    = '0;
`ifdef KS_ARB_SUB_EN
        req_sub   = '0;
`endif
        rsp_ready = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap_skip();
        test_reset_midflight();
        test_random();
`ifdef KS_ARB_SUB_EN
        test_sub();
`endif
        test_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
